// File: rtl/pixel_readout_pkg.sv
// Shared types and constants for the pixel capture-and-stream stage.
package pixel_readout_pkg;

  localparam int PIX_DATA_W    = 8;
  localparam int PIX_PER_FRAME = 4;
  localparam int DROP_CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    ASSEMBLE,
    COMMIT
  } cap_state_t;

  typedef logic [PIX_PER_FRAME-1:0][PIX_DATA_W-1:0] frame_t;

endpackage

// File: rtl/pixel_frame_fifo.sv
// Frame-wide synchronous FIFO; the head entry sits in a register so the
// consumer sees it with no read latency once the FIFO is non-empty.
module pixel_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    rd_ptr_n = do_rd ? ptr_inc(rd_ptr) : rd_ptr;
  end

  // Head register preloads the next head entry, bypassing a write that lands on it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr <= rd_ptr_n;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      rd_data <= (do_wr && (wr_ptr == rd_ptr_n)) ? wr_data : mem[rd_ptr_n];
    end
  end

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pixel_readout.sv
// Captures one-hot sensor pixel reads into whole frames, buffers them in a
// frame FIFO and streams them out over valid/ready with SOF/EOF markers.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int DATA_W      = PIX_DATA_W,
  parameter int N_PIX       = PIX_PER_FRAME,
  parameter int FIFO_FRAMES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [DATA_W-1:0]        DATA_BUS,
  input  logic [N_PIX-1:0]         READ,
  output logic [DATA_W-1:0]        PIX_DATA,
  output logic [$clog2(N_PIX)-1:0] PIX_IDX,
  output logic                     PIX_SOF,
  output logic                     PIX_EOF,
  output logic                     PIX_VALID,
  input  logic                     PIX_READY,
  input  logic                     CLR_ERR,
  output logic                     ERR_DUP,
  output logic                     ERR_MULTI,
  output logic                     ERR_TIMEOUT,
  output logic                     OVERFLOW,
  output logic [DROP_CNT_W-1:0]    DROP_CNT
);

  localparam int IDX_W   = $clog2(N_PIX);
  localparam int TO_W    = $clog2(TIMEOUT + 1);
  localparam int FRAME_W = N_PIX * DATA_W;

  typedef logic [N_PIX-1:0][DATA_W-1:0] slot_frame_t;

  cap_state_t        state;
  cap_state_t        state_n;
  logic [N_PIX-1:0]  read_q;
  logic [N_PIX-1:0]  rise;
  logic [N_PIX-1:0]  ev_bits;
  logic [N_PIX-1:0]  mask;
  logic [N_PIX-1:0]  mask_base;
  logic              ev;
  logic              multi_ev;
  logic              dup_ev;
  logic              frame_done;
  logic              timeout_hit;
  logic [TO_W-1:0]   idle_cnt;
  slot_frame_t       slots;
  slot_frame_t       head;
  logic [FRAME_W-1:0] head_flat;
  logic              push;
  logic              drop;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [IDX_W-1:0]  beat_idx;
  logic              last_beat;
  logic              accept;
  logic [DROP_CNT_W-1:0] drop_base;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) read_q <= '0;
    else          read_q <= READ;
  end

  // A multi-hot READ on a rising edge is a fault and captures nothing.
  always_comb begin
    rise        = READ & ~read_q;
    multi_ev    = (rise != '0) && ((READ & (READ - N_PIX'(1))) != '0);
    ev_bits     = multi_ev ? '0 : rise;
    ev          = (ev_bits != '0);
    mask_base   = (state == COMMIT) ? '0 : mask;
    frame_done  = ev && ((mask_base | ev_bits) == '1);
    dup_ev      = ev && ((mask_base & ev_bits) != '0);
    timeout_hit = (state == ASSEMBLE) && !ev && (idle_cnt == TO_W'(TIMEOUT - 1));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (ev) state_n = frame_done ? COMMIT : ASSEMBLE;
      ASSEMBLE: begin
        if (frame_done)       state_n = COMMIT;
        else if (timeout_hit) state_n = IDLE;
      end
      COMMIT:   state_n = frame_done ? COMMIT : (ev ? ASSEMBLE : IDLE);
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    push = (state == COMMIT) && !fifo_full;
    drop = (state == COMMIT) && fifo_full;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mask     <= '0;
      slots    <= '0;
      idle_cnt <= '0;
    end else begin
      mask <= timeout_hit ? '0 : (mask_base | ev_bits);
      for (int i = 0; i < N_PIX; i++) begin
        if (ev_bits[i]) slots[i] <= DATA_BUS;
      end
      if (ev || (state != ASSEMBLE) || timeout_hit) idle_cnt <= '0;
      else                                          idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  // Sticky flags: a new fault in the same cycle as CLR_ERR keeps the flag set.
  always_comb begin
    drop_base = CLR_ERR ? '0 : DROP_CNT;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ERR_DUP     <= 1'b0;
      ERR_MULTI   <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
      OVERFLOW    <= 1'b0;
      DROP_CNT    <= '0;
    end else begin
      ERR_DUP     <= dup_ev      | (ERR_DUP     & ~CLR_ERR);
      ERR_MULTI   <= multi_ev    | (ERR_MULTI   & ~CLR_ERR);
      ERR_TIMEOUT <= timeout_hit | (ERR_TIMEOUT & ~CLR_ERR);
      OVERFLOW    <= drop        | (OVERFLOW    & ~CLR_ERR);
      DROP_CNT    <= (drop && (drop_base != '1)) ? drop_base + DROP_CNT_W'(1) : drop_base;
    end
  end

  pixel_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_FRAMES)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .wr_en   (push),
    .wr_data (slots),
    .rd_en   (pop),
    .rd_data (head_flat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    head      = head_flat;
    PIX_VALID = !fifo_empty;
    last_beat = (beat_idx == IDX_W'(N_PIX - 1));
    accept    = PIX_VALID && PIX_READY;
    pop       = accept && last_beat;
    PIX_IDX   = beat_idx;
    PIX_DATA  = PIX_VALID ? head[beat_idx] : '0;
    PIX_SOF   = PIX_VALID && (beat_idx == '0);
    PIX_EOF   = PIX_VALID && last_beat;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)    beat_idx <= '0;
    else if (accept) beat_idx <= last_beat ? '0 : beat_idx + IDX_W'(1);
  end

endmodule

// File: tb/tb_pixel_readout.sv
// Directed self-checking bench for pixel_readout: table of single frames plus
// hand-written sequences for latency, overflow, faults, timeout and reset.
module tb_pixel_readout;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] DATA_BUS = 8'h00;
  logic [3:0] READ = 4'h0;
  logic [7:0] PIX_DATA;
  logic [1:0] PIX_IDX;
  logic       PIX_SOF;
  logic       PIX_EOF;
  logic       PIX_VALID;
  logic       PIX_READY = 1'b1;
  logic       CLR_ERR = 1'b0;
  logic       ERR_DUP;
  logic       ERR_MULTI;
  logic       ERR_TIMEOUT;
  logic       OVERFLOW;
  logic [7:0] DROP_CNT;

  pixel_readout dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .DATA_BUS    (DATA_BUS),
    .READ        (READ),
    .PIX_DATA    (PIX_DATA),
    .PIX_IDX     (PIX_IDX),
    .PIX_SOF     (PIX_SOF),
    .PIX_EOF     (PIX_EOF),
    .PIX_VALID   (PIX_VALID),
    .PIX_READY   (PIX_READY),
    .CLR_ERR     (CLR_ERR),
    .ERR_DUP     (ERR_DUP),
    .ERR_MULTI   (ERR_MULTI),
    .ERR_TIMEOUT (ERR_TIMEOUT),
    .OVERFLOW    (OVERFLOW),
    .DROP_CNT    (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] idx;
    logic       sof;
    logic       eof;
  } beat_t;

  // order[k] is the k-th pixel read; val[p] is the bus value for pixel p; exp[k] is beat k
  typedef struct packed {
    logic [3:0][1:0] order;
    logic [3:0][7:0] val;
    logic [3:0][7:0] exp;
  } vec_t;

  beat_t beats[$];
  int vecCount = 0;
  int missCount = 0;

  // Accepted beats are recorded mid-cycle, before the edge that takes them.
  always @(negedge CLK) begin
    if (RESET_N && PIX_VALID && PIX_READY)
      beats.push_back({PIX_DATA, PIX_IDX, PIX_SOF, PIX_EOF});
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input int pix, input logic [7:0] val);
    READ = 4'(1 << pix);
    DATA_BUS = val;
    tick(1);
    READ = 4'h0;
    DATA_BUS = 8'h00;
    tick(1);
  endtask

  task automatic clearErrors();
    CLR_ERR = 1'b1;
    tick(1);
    CLR_ERR = 1'b0;
  endtask

  task automatic waitBeats(input int n, input string name);
    int budget = 60;
    while (beats.size() < n && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    checkOutput({name, "_beat_count"}, 32'(beats.size()), 32'(n));
    tick(1);
  endtask

  task automatic checkFrame(input string name, input logic [3:0][7:0] exp);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      if (beats.size() > 0) b = beats.pop_front();
      else b = '0;
      checkOutput($sformatf("%s_b%0d_data", name, k), 32'(b.data), 32'(exp[k]));
      checkOutput($sformatf("%s_b%0d_idx", name, k), 32'(b.idx), 32'(k));
      checkOutput($sformatf("%s_b%0d_sof_eof", name, k), 32'({b.sof, b.eof}),
                  32'({k == 0, k == 3}));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[3];
    vecs[0] = '{order: {2'd0, 2'd1, 2'd2, 2'd3},
                val:   {8'hD3, 8'hC2, 8'hB1, 8'hA0},
                exp:   {8'hD3, 8'hC2, 8'hB1, 8'hA0}};
    vecs[1] = '{order: {2'd1, 2'd3, 2'd0, 2'd2},
                val:   {8'h80, 8'h00, 8'h7F, 8'hFF},
                exp:   {8'h80, 8'h00, 8'h7F, 8'hFF}};
    vecs[2] = '{order: {2'd2, 2'd0, 2'd3, 2'd1},
                val:   {8'h5A, 8'hA5, 8'h3C, 8'hC3},
                exp:   {8'h5A, 8'hA5, 8'h3C, 8'hC3}};

    // reset state
    tick(3);
    checkOutput("rst_valid", 32'(PIX_VALID), 32'd0);
    checkOutput("rst_data", 32'(PIX_DATA), 32'd0);
    checkOutput("rst_idx", 32'(PIX_IDX), 32'd0);
    checkOutput("rst_sof_eof", 32'({PIX_SOF, PIX_EOF}), 32'd0);
    checkOutput("rst_errs", 32'({ERR_DUP, ERR_MULTI, ERR_TIMEOUT, OVERFLOW}), 32'd0);
    checkOutput("rst_drop_cnt", 32'(DROP_CNT), 32'd0);
    RESET_N = 1'b1;
    tick(2);

    // first frame and its latency: valid appears two cycles after the last read
    applyStimulus(0, 8'h11);
    applyStimulus(1, 8'h22);
    applyStimulus(2, 8'h33);
    READ = 4'b1000;
    DATA_BUS = 8'h44;
    tick(1);
    READ = 4'h0;
    @(negedge CLK);
    checkOutput("lat_valid_T+1", 32'(PIX_VALID), 32'd0);
    @(negedge CLK);
    checkOutput("lat_valid_T+2", 32'(PIX_VALID), 32'd1);
    tick(1);
    waitBeats(4, "lat");
    checkFrame("lat", {8'h44, 8'h33, 8'h22, 8'h11});

    // table-driven frames in assorted read orders
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 4; k++)
        applyStimulus(int'(vecs[v].order[k]), vecs[v].val[vecs[v].order[k]]);
      waitBeats(4, $sformatf("vec%0d", v));
      checkFrame($sformatf("vec%0d", v), vecs[v].exp);
    end

    // back-pressure: two frames held, third dropped
    tick(2);
    beats.delete();
    PIX_READY = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < 4; p++)
        applyStimulus(p, 8'(8'h10 * (f + 1) + p));
    tick(4);
    checkOutput("ovf_flag", 32'(OVERFLOW), 32'd1);
    checkOutput("ovf_drop_cnt", 32'(DROP_CNT), 32'd1);
    checkOutput("ovf_no_beats", 32'(beats.size()), 32'd0);
    checkOutput("ovf_hold_valid", 32'(PIX_VALID), 32'd1);
    tick(3);
    checkOutput("ovf_hold_data", 32'(PIX_DATA), 32'h10);
    checkOutput("ovf_hold_sof", 32'({PIX_SOF, PIX_IDX}), 32'b100);
    PIX_READY = 1'b1;
    tick(20);
    checkOutput("ovf_release_beats", 32'(beats.size()), 32'd8);
    checkFrame("ovf_f1", {8'h13, 8'h12, 8'h11, 8'h10});
    checkFrame("ovf_f2", {8'h23, 8'h22, 8'h21, 8'h20});
    clearErrors();
    checkOutput("ovf_clr_flag", 32'(OVERFLOW), 32'd0);
    checkOutput("ovf_clr_cnt", 32'(DROP_CNT), 32'd0);

    // duplicate read of pixel 1: last value wins
    beats.delete();
    applyStimulus(0, 8'h01);
    applyStimulus(1, 8'h05);
    applyStimulus(1, 8'h09);
    applyStimulus(2, 8'h0A);
    applyStimulus(3, 8'h0B);
    waitBeats(4, "dup");
    checkOutput("dup_flag", 32'(ERR_DUP), 32'd1);
    checkFrame("dup", {8'h0B, 8'h0A, 8'h09, 8'h01});
    clearErrors();
    checkOutput("dup_clr", 32'(ERR_DUP), 32'd0);

    // multi-hot READ captures nothing; fault beats a simultaneous clear
    beats.delete();
    READ = 4'b0011;
    DATA_BUS = 8'hEE;
    tick(1);
    READ = 4'h0;
    tick(1);
    checkOutput("multi_flag", 32'(ERR_MULTI), 32'd1);
    applyStimulus(2, 8'h62);
    applyStimulus(3, 8'h63);
    tick(10);
    checkOutput("multi_no_capture", 32'(beats.size()), 32'd0);
    applyStimulus(0, 8'h60);
    applyStimulus(1, 8'h61);
    waitBeats(4, "multi");
    checkFrame("multi", {8'h63, 8'h62, 8'h61, 8'h60});
    READ = 4'b0101;
    CLR_ERR = 1'b1;
    tick(1);
    READ = 4'h0;
    CLR_ERR = 1'b0;
    tick(1);
    checkOutput("multi_wins_clr", 32'(ERR_MULTI), 32'd1);
    clearErrors();
    checkOutput("multi_clr", 32'(ERR_MULTI), 32'd0);

    // partial frame abandoned after 64 idle cycles
    beats.delete();
    applyStimulus(0, 8'h55);
    applyStimulus(1, 8'h66);
    tick(60);
    checkOutput("to_not_yet", 32'(ERR_TIMEOUT), 32'd0);
    tick(4);
    checkOutput("to_flag", 32'(ERR_TIMEOUT), 32'd1);
    checkOutput("to_no_beats", 32'(beats.size()), 32'd0);
    applyStimulus(0, 8'h01);
    applyStimulus(1, 8'h02);
    applyStimulus(2, 8'h03);
    applyStimulus(3, 8'h04);
    waitBeats(4, "to");
    checkFrame("to", {8'h04, 8'h03, 8'h02, 8'h01});
    clearErrors();
    checkOutput("to_clr", 32'(ERR_TIMEOUT), 32'd0);

    // reset asserted after two beats of a stream
    PIX_READY = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 4; p++)
        applyStimulus(p, 8'(8'h70 + 8'h10 * f + p));
    tick(3);
    beats.delete();
    PIX_READY = 1'b1;
    tick(2);
    RESET_N = 1'b0;
    #1;
    checkOutput("rstm_valid", 32'(PIX_VALID), 32'd0);
    checkOutput("rstm_data", 32'(PIX_DATA), 32'd0);
    checkOutput("rstm_beats", 32'(beats.size()), 32'd2);
    tick(2);
    RESET_N = 1'b1;
    tick(20);
    checkOutput("rstm_no_residual", 32'(beats.size()), 32'd2);
    checkOutput("rstm_beat0", 32'(beats.size() > 0 ? beats[0].data : 8'hXX), 32'h70);
    checkOutput("rstm_beat1", 32'(beats.size() > 1 ? beats[1].data : 8'hXX), 32'h71);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
